// File: rtl/mult_sequencer.sv
// Control sequencer for a shift-add multiplier: issues Load, Add and Shift strobes for WIDTH
// iterations and provides a Start/Busy/Done handshake for pipeline stall logic.
module mult_sequencer #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             q0_i,
  output logic             load_o,
  output logic             add_en_o,
  output logic             shift_en_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             k_o,
  output logic [CNT_W-1:0] iter_o
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StTest,
    StAdd,
    StShift,
    StDone
  } state_e;

  localparam logic [CNT_W-1:0] IterLast = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic             load_q, add_en_q, shift_en_q, busy_q, done_q;
  logic             k;

  assign k = (iter_q == IterLast);

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    case (state_q)
      StIdle: begin
        if (start_i) state_d = StLoad;
      end
      StLoad: begin
        iter_d  = '0;
        state_d = StTest;
      end
      StTest: begin
        state_d = q0_i ? StAdd : StShift;
      end
      StAdd: begin
        state_d = StShift;
      end
      StShift: begin
        if (k) begin
          state_d = StDone;
        end else begin
          iter_d  = iter_q + CNT_W'(1);
          state_d = StTest;
        end
      end
      StDone: begin
        // Clearing here keeps K low whenever the sequencer is idle.
        iter_d  = '0;
        state_d = StIdle;
      end
      default: begin
        iter_d  = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Strobes are registered from the next state so each is a clean Moore output of the flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      iter_q     <= '0;
      load_q     <= 1'b0;
      add_en_q   <= 1'b0;
      shift_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      iter_q     <= iter_d;
      load_q     <= (state_d == StLoad);
      add_en_q   <= (state_d == StAdd);
      shift_en_q <= (state_d == StShift);
      busy_q     <= (state_d != StIdle);
      done_q     <= (state_d == StDone);
    end
  end

  assign load_o     = load_q;
  assign add_en_o   = add_en_q;
  assign shift_en_o = shift_en_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign k_o        = k;
  assign iter_o     = iter_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer: a small shift-add datapath model supplies Q0, and a scoreboard of
// expected latency/strobe counts/product is checked when Done appears.
module tb_mult_sequencer;

  localparam int unsigned W = 8;
  localparam int unsigned CW = $clog2(W);
  localparam int Budget = 100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          q0;
  logic          load, add_en, shift_en, busy, done, k;
  logic [CW-1:0] iter;

  int total = 0;
  int bad = 0;

  mult_sequencer #(.WIDTH(W)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .q0_i       (q0),
    .load_o     (load),
    .add_en_o   (add_en),
    .shift_en_o (shift_en),
    .busy_o     (busy),
    .done_o     (done),
    .k_o        (k),
    .iter_o     (iter)
  );

  always #5 clk = ~clk;

  // Datapath model: {carry, accumulator, multiplier} product register.
  logic [W-1:0]   mc_r = '0;
  logic [W-1:0]   mp_r = '0;
  logic [2*W:0]   prod = '0;
  assign q0 = prod[0];

  always @(posedge clk) begin
    if (load)          prod <= {{(W + 1){1'b0}}, mp_r};
    else if (add_en)   prod[2*W:W] <= prod[2*W:W] + {1'b0, mc_r};
    else if (shift_en) prod <= prod >> 1;
  end

  typedef struct {
    int          lat;
    int          adds;
    int          kcyc;
    logic [15:0] prod;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    string       name;
    logic [7:0]  mc;
    logic [7:0]  mp;
    int          lat;
    int          adds;
    int          kcyc;
    logic [15:0] prod;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Runs one operation from idle; optional Start abuse during and at the end of the operation.
  task automatic run_op(input string name, input logic [7:0] mc, input logic [7:0] mp,
                        input int lat, input int adds, input int kcyc, input logic [15:0] p,
                        input bit abuse);
    exp_t e;
    exp_t got;
    int   loads = 0, nadd = 0, nsh = 0, nbusy = 0, nk = 0, viol = 0, seen_lat = 0;
    e.lat = lat; e.adds = adds; e.kcyc = kcyc; e.prod = p;
    sb.push_back(e);
    mc_r = mc;
    mp_r = mp;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= Budget; c++) begin
      @(negedge clk);
      if (abuse) start = (c == 3 || c == 10);
      loads += int'(load);
      nadd  += int'(add_en);
      nsh   += int'(shift_en);
      nbusy += int'(busy);
      nk    += int'(k);
      if ((add_en && shift_en) || (load && (add_en || shift_en))) viol++;
      if (done) begin
        seen_lat = c;
        break;
      end
    end
    got = sb.pop_front();
    if (seen_lat == 0) begin
      chk({name, " done timeout"}, 0, 1);
    end else begin
      chk({name, " latency"}, seen_lat, got.lat);
      chk({name, " add pulses"}, nadd, got.adds);
      chk({name, " shift pulses"}, nsh, W);
      chk({name, " load pulses"}, loads, 1);
      chk({name, " busy cycles"}, nbusy, got.lat);
      chk({name, " k cycles"}, nk, got.kcyc);
      chk({name, " strobe overlap"}, viol, 0);
      chk({name, " product"}, int'(prod[2*W-1:0]), int'(got.prod));
    end
    if (abuse) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk({name, " idle after done"}, int'(busy | load | k), 0);
  endtask

  task automatic wait_done(input string name, output int lat);
    lat = 0;
    for (int c = 1; c <= Budget; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
    end
    if (lat == 0) chk({name, " done timeout"}, 0, 1);
  endtask

  vec_t vecs[5];
  int   lat;

  initial begin
    vecs[0] = '{"zeros", 8'h55, 8'h00, 18, 0, 3, 16'd0};
    vecs[1] = '{"ones",  8'hFF, 8'hFF, 26, 8, 4, 16'd65025};
    vecs[2] = '{"p8d",   8'd13, 8'h8D, 22, 4, 4, 16'd1833};
    vecs[3] = '{"pa5",   8'h3C, 8'hA5, 22, 4, 4, 16'd9900};
    vecs[4] = '{"p01",   8'h80, 8'h01, 19, 1, 3, 16'd128};

    // Asynchronous reset between edges.
    #22 rst_n = 1'b0;
    #1;
    chk("reset outputs", int'({load, add_en, shift_en, busy, done, k}), 0);
    chk("reset iter", int'(iter), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle no activity", int'({load, add_en, shift_en, busy, done, k}), 0);
    end

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].mc, vecs[i].mp, vecs[i].lat, vecs[i].adds, vecs[i].kcyc,
             vecs[i].prod, 1'b0);

    run_op("abuse", 8'd13, 8'h8D, 22, 4, 4, 16'd1833, 1'b1);

    // Start held high: back-to-back operations with one idle cycle between.
    mc_r = 8'h00;
    mp_r = 8'h00;
    start = 1'b1;
    wait_done("held op1", lat);
    chk("held op1 latency", lat, 18);
    @(negedge clk);
    chk("held gap idle", int'(busy), 0);
    @(negedge clk);
    chk("held relaunch load", int'(load), 1);
    wait_done("held op2", lat);
    chk("held op2 latency", lat + 1, 18);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset during ADD at iter 4.
    mc_r = 8'h11;
    mp_r = 8'hFF;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    for (int c = 1; c <= Budget; c++) begin
      @(negedge clk);
      if (add_en && iter == CW'(4)) begin
        lat = c;
        break;
      end
    end
    chk("reach add iter4", int'(lat != 0), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midop reset outputs", int'({load, add_en, shift_en, busy, done, k}), 0);
    chk("midop reset iter", int'(iter), 0);
    lat = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      lat += int'(done | busy);
      if (i == 1) rst_n = 1'b1;
    end
    chk("no done after reset", lat, 0);
    run_op("post reset", 8'hFF, 8'hFF, 26, 8, 4, 16'd65025, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
